// File: rtl/om_otf_converter.sv
// om_otf_converter: on-the-fly conversion of an MSD-first signed-digit stream
// z in {-1,0,+1} into an (N+1)-bit two's-complement integer equal to x*2^N.
// Uses the Q/QM register pair, so no carry propagation is needed per digit.
// Optional build macro: OM_OTF_SKIP_EN -- when defined, the first DELTA
// accepted digits after start are consumed without updating Q/QM. A nonzero
// or illegal skipped digit flags err.
module om_otf_converter #(
  parameter int N     = 8,
  parameter int DELTA = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   z,
  input  logic         z_valid,
  output logic         z_ready,
  output logic [N:0]   q,
  output logic         err,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

`ifdef OM_OTF_SKIP_EN
  localparam int SKIP = DELTA;
`else
  // DELTA still appears so the parameter list is identical in both builds.
  localparam int SKIP = DELTA * 0;
`endif

  localparam int              TOTAL = N + SKIP;
  localparam int              CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0]   LAST  = CW'(TOTAL - 1);

  logic [1:0]    state_q, state_d;
  logic [N:0]    acc_q, acc_d;     // Q: value of digits converted so far
  logic [N:0]    accm_q, accm_d;   // QM: always Q-1
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [N:0]    res_q, res_d;

  logic          in_skip;
  logic [N:0]    acc_upd, accm_upd;
  logic          dig_pos, dig_neg, dig_bad;

  // Leading digits discarded only when the skip build is selected.
  generate
    if (SKIP > 0) begin : g_skip
      assign in_skip = (cnt_q < CW'(SKIP));
    end else begin : g_noskip
      assign in_skip = 1'b0;
    end
  endgenerate

  assign dig_pos = (z == 2'b10);
  assign dig_neg = (z == 2'b01);
  assign dig_bad = (z == 2'b11);

  // On-the-fly append: select the Q or QM prefix, never add.
  always_comb begin
    acc_upd  = {acc_q[N-1:0], 1'b0};
    accm_upd = {accm_q[N-1:0], 1'b1};
    if (dig_pos) begin
      acc_upd  = {acc_q[N-1:0], 1'b1};
      accm_upd = {acc_q[N-1:0], 1'b0};
    end else if (dig_neg) begin
      acc_upd  = {accm_q[N-1:0], 1'b1};
      accm_upd = {accm_q[N-1:0], 1'b0};
    end
  end

  // Next-state logic for the IDLE/RUN/DONE controller and datapath.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    accm_d  = accm_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = '0;
          accm_d  = '1;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (z_valid) begin
          cnt_d = cnt_q + CW'(1);
          if (in_skip) begin
            if (z != 2'b00) err_d = 1'b1;
          end else begin
            acc_d  = acc_upd;
            accm_d = accm_upd;
            if (dig_bad) err_d = 1'b1;
          end
          if (cnt_q == LAST) begin
            state_d = ST_DONE;
            res_d   = acc_upd;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      accm_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      accm_q  <= accm_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end

  assign z_ready   = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign q         = res_q;
  assign err       = err_q;

endmodule
